// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: the display line fetch has absolute priority and the pixel writer gets idle cycles.
// Optional FB_ARB_PERF_EN adds oWrStallCnt, a saturating count of stalled writer cycles.
module vga_fb_arbiter #(
  parameter int unsigned WIDTH        = 640,
  parameter int unsigned HEIGHT       = 480,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned PIX_PER_WORD = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned WORDS        = WIDTH / PIX_PER_WORD,
  parameter int unsigned LB_AW        = 7
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [9:0]        iCountH,
  input  logic [9:0]        iCountV,
  input  logic              iWrReq,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oWrAck,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic              oMemWe,
  output logic [DATA_W-1:0] oMemWData,
  input  logic [DATA_W-1:0] iMemRData,
  output logic              oLbWe,
  output logic [LB_AW-1:0]  oLbAddr,
  output logic [DATA_W-1:0] oLbData,
  output logic              oLbBank,
`ifdef FB_ARB_PERF_EN
  output logic [15:0]       oWrStallCnt,
`endif
  output logic              oFetching
);

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [LB_AW-1:0]  r_k;
  logic              r_bank;
  logic              r_v2;
  logic [LB_AW-1:0]  r_i2;

  logic [9:0]        w_nr;
  logic              w_trigger;
  logic [ADDR_W-1:0] w_base;
  logic              w_last;
  logic              w_grant;

  // Row to fetch for the line after this one, and its framebuffer base address
  assign w_nr      = (iCountV == 10'(V_TOTAL - 1)) ? 10'd0 : iCountV + 10'd1;
  assign w_trigger = (iCountH == 10'(WIDTH)) && (w_nr < 10'(HEIGHT));
  assign w_base    = ADDR_W'(32'(w_nr) * WORDS);
  assign w_last    = (r_k == LB_AW'(WORDS - 1));

  // The writer may also take the port on the edge that retires the last fetch address
  assign w_grant = iWrReq && !oWrAck &&
                   (((r_state == S_IDLE) && !w_trigger) ||
                    ((r_state == S_FETCH) && w_last));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_k       <= '0;
      r_bank    <= 1'b0;
      r_v2      <= 1'b0;
      r_i2      <= '0;
      oWrAck    <= 1'b0;
      oMemAddr  <= '0;
      oMemWe    <= 1'b0;
      oMemWData <= '0;
      oLbWe     <= 1'b0;
      oLbAddr   <= '0;
      oLbData   <= '0;
      oLbBank   <= 1'b0;
      oFetching <= 1'b0;
    end else begin
      oMemWe <= 1'b0;
      oWrAck <= 1'b0;

      // Read pipeline: address stage (oFetching, r_k), then data stage (r_v2, r_i2)
      r_v2  <= oFetching;
      r_i2  <= r_k;
      oLbWe <= r_v2;
      if (r_v2) begin
        oLbAddr <= r_i2;
        oLbData <= iMemRData;
        oLbBank <= r_bank;
      end

      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_state   <= S_FETCH;
            r_base    <= w_base;
            r_bank    <= w_nr[0];
            r_k       <= '0;
            oMemAddr  <= w_base;
            oFetching <= 1'b1;
          end
        end
        S_FETCH: begin
          if (w_last) begin
            r_state   <= S_IDLE;
            oFetching <= 1'b0;
          end else begin
            r_k      <= r_k + LB_AW'(1);
            oMemAddr <= r_base + ADDR_W'(r_k) + ADDR_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_grant) begin
        oMemAddr  <= iWrAddr;
        oMemWData <= iWrData;
        oMemWe    <= 1'b1;
        oWrAck    <= 1'b1;
      end
    end
  end

`ifdef FB_ARB_PERF_EN
  // Writer stall cycles since frame start
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oWrStallCnt <= '0;
    end else if ((iCountH == 10'd0) && (iCountV == 10'd0)) begin
      oWrStallCnt <= '0;
    end else if (iWrReq && !oWrAck && (oWrStallCnt != 16'hFFFF)) begin
      oWrStallCnt <= oWrStallCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter: a behavioural RAM plus a line/cycle-rule reference model.
// Define FB_ARB_PERF_EN to also check oWrStallCnt.
module tb_vga_fb_arbiter;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LB_AW  = 7;
  localparam int unsigned WORDS  = 80;

  logic              iClk = 1'b0;
  logic              iRst;
  logic [9:0]        iCountH, iCountV;
  logic              iWrReq;
  logic [ADDR_W-1:0] iWrAddr;
  logic [DATA_W-1:0] iWrData;
  logic              oWrAck;
  logic [ADDR_W-1:0] oMemAddr;
  logic              oMemWe;
  logic [DATA_W-1:0] oMemWData;
  logic [DATA_W-1:0] iMemRData;
  logic              oLbWe;
  logic [LB_AW-1:0]  oLbAddr;
  logic [DATA_W-1:0] oLbData;
  logic              oLbBank;
  logic              oFetching;
`ifdef FB_ARB_PERF_EN
  logic [15:0]       oWrStallCnt;
`endif

  always #5 iClk = ~iClk;

  vga_fb_arbiter dut (
    .iClk(iClk), .iRst(iRst), .iCountH(iCountH), .iCountV(iCountV),
    .iWrReq(iWrReq), .iWrAddr(iWrAddr), .iWrData(iWrData), .oWrAck(oWrAck),
    .oMemAddr(oMemAddr), .oMemWe(oMemWe), .oMemWData(oMemWData), .iMemRData(iMemRData),
    .oLbWe(oLbWe), .oLbAddr(oLbAddr), .oLbData(oLbData), .oLbBank(oLbBank),
`ifdef FB_ARB_PERF_EN
    .oWrStallCnt(oWrStallCnt),
`endif
    .oFetching(oFetching)
  );

  // Single-port RAM, read data one cycle after the address
  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];
  always @(posedge iClk) begin
    iMemRData <= ram[oMemAddr];
    if (oMemWe) ram[oMemAddr] <= oMemWData;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t H=%0d V=%0d)", tag, got, exp, $time, iCountH, iCountV);
  endtask

  // Expected outputs for the coming cycle
  bit          e_ack, e_fetch, e_memwe, e_addr_chk, e_lbwe, e_lbbank;
  int          e_addr, e_wdata, e_lbaddr;
  int          stall_e;
  logic [7:0]  lbq[$];
  bit          rst_pending;

  task automatic check_zero(input string tag);
    check({tag, "_ack"},   32'(oWrAck), 0);
    check({tag, "_addr"},  32'(oMemAddr), 0);
    check({tag, "_we"},    32'(oMemWe), 0);
    check({tag, "_wdata"}, 32'(oMemWData), 0);
    check({tag, "_lbwe"},  32'(oLbWe), 0);
    check({tag, "_lbaddr"},32'(oLbAddr), 0);
    check({tag, "_lbdata"},32'(oLbData), 0);
    check({tag, "_lbbank"},32'(oLbBank), 0);
    check({tag, "_fetch"}, 32'(oFetching), 0);
`ifdef FB_ARB_PERF_EN
    check({tag, "_stall"}, 32'(oWrStallCnt), 0);
`endif
  endtask

  task automatic model_reset();
    e_ack = 0; e_fetch = 0; e_memwe = 0; e_addr_chk = 0; e_lbwe = 0;
    e_lbbank = 0; e_addr = 0; e_wdata = 0; e_lbaddr = 0; stall_e = 0;
    lbq.delete();
  endtask

  // Sweep one scan line over H = h0..h1; rst_at >= 0 pulses reset at that H, coll forces the collision write
  task automatic run_line(input int v, input int h0, input int h1, input int rst_at, input bit coll);
    int  nr;
    bit  fl;
    bit  n_ack;
    int  stall_640;
    nr = (v == 524) ? 0 : v + 1;
    fl = (h0 <= 640) && (h1 >= 640) && (nr < 480);
    stall_640 = 0;
    for (int h = h0; h <= h1; h++) begin
      @(negedge iClk);
      if (rst_pending) begin
        iRst = 1'b0;
        rst_pending = 0;
      end
      // Outputs of this cycle
      check("fetching", 32'(oFetching), 32'(e_fetch));
      check("wr_ack", 32'(oWrAck), 32'(e_ack));
      check("mem_we", 32'(oMemWe), 32'(e_memwe));
      if (e_addr_chk) check("mem_addr", 32'(oMemAddr), 32'(e_addr));
      if (e_ack) check("mem_wdata", 32'(oMemWData), 32'(e_wdata));
      check("lb_we", 32'(oLbWe), 32'(e_lbwe));
      if (e_lbwe) begin
        check("lb_addr", 32'(oLbAddr), 32'(e_lbaddr));
        check("lb_bank", 32'(oLbBank), 32'(e_lbbank));
        if (lbq.size() == 0) check("lb_queue", 32'(0), 32'(1));
        else check("lb_data", 32'(oLbData), 32'(lbq.pop_front()));
      end
`ifdef FB_ARB_PERF_EN
      check("stall_cnt", 32'(oWrStallCnt), 32'(stall_e));
      if (coll && h == 640) stall_640 = stall_e;
      if (coll && h == 721) check("coll_stall81", 32'(oWrStallCnt), 32'(stall_640 + 81));
`endif
      if (coll && h == 720) check("coll_noack", 32'(oWrAck), 0);
      if (coll && h == 721) begin
        check("coll_ack", 32'(oWrAck), 1);
        check("coll_addr", 32'(oMemAddr), 32'h1234);
        check("coll_data", 32'(oMemWData), 32'hA5);
      end
      if (e_fetch) lbq.push_back(ref_mem[e_addr]);
      if (e_ack) ref_mem[e_addr] = 8'(e_wdata);

      // Inputs for this cycle
      iCountH = 10'(h);
      iCountV = 10'(v);
      if (!(coll && h >= 620 && h < 640)) begin
        if (iWrReq && oWrAck) begin
          if ($urandom_range(0, 1) == 1) begin
            iWrAddr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 239));
            iWrData = 8'($urandom);
          end else begin
            iWrReq = 1'b0;
          end
        end else if (!iWrReq && $urandom_range(0, 2) == 0) begin
          iWrReq  = 1'b1;
          iWrAddr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 239));
          iWrData = 8'($urandom);
        end
      end else if (iWrReq && oWrAck) begin
        iWrReq = 1'b0;
      end
      if (coll && h == 640) begin
        iWrReq  = 1'b1;
        iWrAddr = 16'h1234;
        iWrData = 8'hA5;
      end

      if (h == rst_at) begin
        iWrReq = 1'b0;
        #1 iRst = 1'b1;
        #1 check_zero("async_rst");
        model_reset();
        fl = 0;
        rst_pending = 1;
      end else begin
        // Expectations for the next cycle
        n_ack = iWrReq && !e_ack && !(fl && h >= 640 && h <= 719);
        if (h == 0 && v == 0) stall_e = 0;
        else if (iWrReq && !e_ack && stall_e != 32'hFFFF) stall_e++;
        e_fetch = fl && (h + 1 >= 641) && (h + 1 <= 720);
        e_memwe = n_ack;
        e_wdata = int'(iWrData);
        e_addr_chk = n_ack || e_fetch;
        if (n_ack) e_addr = int'(iWrAddr);
        else if (e_fetch) e_addr = nr * WORDS + (h + 1 - 641);
        e_lbwe   = fl && (h + 1 >= 643) && (h + 1 <= 722);
        e_lbaddr = h + 1 - 643;
        e_lbbank = nr[0];
        e_ack    = n_ack;
      end
    end
  endtask

  initial begin
    int vs [8] = '{0, 1, 524, 479, 478, 480, 523, 200};
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    iRst = 1'b0; iCountH = '0; iCountV = '0;
    iWrReq = 1'b0; iWrAddr = '0; iWrData = '0;
    rst_pending = 0;
    model_reset();
    #1 iRst = 1'b1;
    @(negedge iClk);
    @(negedge iClk);
    check_zero("reset");
    iRst = 1'b0;

    run_line(0,   600, 760, -1, 1'b1);  // row 1 with a colliding write
    run_line(524, 600, 760, -1, 1'b0);  // wrap to row 0
    run_line(479, 600, 760, -1, 1'b0);  // no fetch
    run_line(0,   600, 760, 660, 1'b0); // reset mid-fetch
    run_line(0,   600, 760, -1, 1'b0);  // recovery
    run_line(0,   0,   20,  -1, 1'b0);  // frame start
    for (int i = 0; i < 20; i++)
      run_line(vs[$urandom_range(0, 7)], 600, 760, -1, 1'b0);
    run_line(0,   0,   20,  -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
